// File: rtl/fetch_pc_unit_if.sv
// Fetch-stage bus: control inputs, instruction ROM port and IF/ID pipeline register outputs.
// The master modport is the fetch unit; the slave modport is the surrounding pipeline and ROM.
interface fetch_pc_unit_if;
    logic        stall;
    logic        flush;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] im_addr;
    logic [31:0] im_instr;
    logic [31:0] d_pc;
    logic [31:0] d_instr;
    logic        d_valid;
    logic        d_fetch_err;

    modport master (
        input  stall, flush, redirect_valid, redirect_pc, im_instr,
        output im_addr, d_pc, d_instr, d_valid, d_fetch_err
    );

    modport slave (
        output stall, flush, redirect_valid, redirect_pc, im_instr,
        input  im_addr, d_pc, d_instr, d_valid, d_fetch_err
    );
endinterface

// File: rtl/fetch_pc_unit.sv
// MIPS IF stage: PC register with stall/redirect, and the IF/ID register with flush and
// fetch-fault tagging for misaligned or out-of-window addresses.
module fetch_pc_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter logic [31:0] IM_BASE  = 32'h0000_3000,
    parameter logic [31:0] IM_LIMIT = 32'h0000_6ffc
) (
    input  logic              clk,
    input  logic              reset,
    fetch_pc_unit_if.master   bus
);

    logic [31:0] pc_q, pc_d;
    logic [31:0] d_pc_q, d_pc_d;
    logic [31:0] d_instr_q, d_instr_d;
    logic        d_valid_q, d_valid_d;
    logic        d_fetch_err_q, d_fetch_err_d;
    logic        fetch_err;

    assign fetch_err = (pc_q[1:0] != 2'b00) | (pc_q < IM_BASE) | (pc_q > IM_LIMIT);

    // A stalled decode stage re-asserts its redirect, so it is dropped while stalled.
    always_comb begin
        pc_d = pc_q;
        if (!bus.stall) begin
            pc_d = bus.redirect_valid ? bus.redirect_pc : pc_q + 32'd4;
        end
    end

    always_comb begin
        d_pc_d        = d_pc_q;
        d_instr_d     = d_instr_q;
        d_valid_d     = d_valid_q;
        d_fetch_err_d = d_fetch_err_q;
        if (bus.flush) begin
            d_pc_d        = pc_q;
            d_instr_d     = 32'h0;
            d_valid_d     = 1'b0;
            d_fetch_err_d = 1'b0;
        end else if (!bus.stall) begin
            d_pc_d        = pc_q;
            d_instr_d     = fetch_err ? 32'h0 : bus.im_instr;
            d_valid_d     = 1'b1;
            d_fetch_err_d = fetch_err;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q          <= RESET_PC;
            d_pc_q        <= 32'h0;
            d_instr_q     <= 32'h0;
            d_valid_q     <= 1'b0;
            d_fetch_err_q <= 1'b0;
        end else begin
            pc_q          <= pc_d;
            d_pc_q        <= d_pc_d;
            d_instr_q     <= d_instr_d;
            d_valid_q     <= d_valid_d;
            d_fetch_err_q <= d_fetch_err_d;
        end
    end

    assign bus.im_addr     = pc_q;
    assign bus.d_pc        = d_pc_q;
    assign bus.d_instr     = d_instr_q;
    assign bus.d_valid     = d_valid_q;
    assign bus.d_fetch_err = d_fetch_err_q;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit: a fetch-record model checked every cycle, plus
// hand-computed literal expectations for each scenario.
module tb_fetch_pc_unit;

    localparam logic [31:0] RST_PC = 32'h0000_3000;
    localparam logic [31:0] LO     = 32'h0000_3000;
    localparam logic [31:0] HI     = 32'h0000_6ffc;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    fetch_pc_unit_if bus ();

    fetch_pc_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] rom(input logic [31:0] a);
        return 32'h8c00_0000 ^ a;
    endfunction

    function automatic logic illegal(input logic [31:0] a);
        return (a % 4 != 0) || (a < LO) || (a > HI);
    endfunction

    assign bus.im_instr = rom(bus.im_addr);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Model: the address being fetched and the record of the last instruction handed on.
    logic [31:0] m_pc;
    logic [31:0] m_dpc;
    logic [31:0] m_dinstr;
    logic        m_dvalid;
    logic        m_derr;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_pc     <= RST_PC;
            m_dpc    <= 32'h0;
            m_dinstr <= 32'h0;
            m_dvalid <= 1'b0;
            m_derr   <= 1'b0;
        end else begin
            if (bus.flush || !bus.stall) begin
                m_dpc    <= m_pc;
                m_dvalid <= !bus.flush;
                m_derr   <= !bus.flush && illegal(m_pc);
                m_dinstr <= (bus.flush || illegal(m_pc)) ? 32'h0 : rom(m_pc);
            end
            if (!bus.stall) m_pc <= bus.redirect_valid ? bus.redirect_pc : m_pc + 32'd4;
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            chk("im_addr", bus.im_addr, m_pc);
            chk("d_pc", bus.d_pc, m_dpc);
            chk("d_instr", bus.d_instr, m_dinstr);
            chk("d_valid", {31'h0, bus.d_valid}, {31'h0, m_dvalid});
            chk("d_fetch_err", {31'h0, bus.d_fetch_err}, {31'h0, m_derr});
        end
    end

    task automatic edges(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic redirect(input logic [31:0] tgt);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = tgt;
        edges(1);
        bus.redirect_valid = 1'b0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        bus.stall = 1'b0;
        bus.flush = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        edges(2);
        chk("rst_pc", bus.im_addr, 32'h3000);
        chk("rst_valid", {31'h0, bus.d_valid}, 32'h0);
        reset = 1'b0;

        // Sequential fetch
        edges(1);
        chk("seq0_pc", bus.d_pc, 32'h3000);
        chk("seq0_valid", {31'h0, bus.d_valid}, 32'h1);
        chk("seq0_instr", bus.d_instr, 32'h8c00_3000);
        edges(1);
        chk("seq1_pc", bus.d_pc, 32'h3004);

        // Redirect with delay slot
        redirect(32'h3040);
        chk("slot_pc", bus.d_pc, 32'h3008);
        edges(1);
        chk("tgt_pc", bus.d_pc, 32'h3040);
        chk("tgt_instr", bus.d_instr, 32'h8c00_3040);

        // Stall with an ignored redirect
        redirect(32'h3010);
        bus.stall = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h3080;
        edges(3);
        chk("stall_pc", bus.im_addr, 32'h3010);
        chk("stall_dpc", bus.d_pc, 32'h3044);
        bus.stall = 1'b0;
        bus.redirect_valid = 1'b0;
        edges(1);
        chk("unstall_dpc", bus.d_pc, 32'h3010);

        // Flush alone, then flush with stall
        bus.flush = 1'b1;
        edges(1);
        chk("flush_valid", {31'h0, bus.d_valid}, 32'h0);
        chk("flush_instr", bus.d_instr, 32'h0);
        chk("flush_next", bus.im_addr, 32'h3018);
        bus.stall = 1'b1;
        edges(1);
        chk("fs_pc", bus.im_addr, 32'h3018);
        chk("fs_valid", {31'h0, bus.d_valid}, 32'h0);
        bus.stall = 1'b0;
        bus.flush = 1'b0;

        // Illegal targets
        redirect(32'h3002);
        edges(1);
        chk("mis_err", {31'h0, bus.d_fetch_err}, 32'h1);
        chk("mis_instr", bus.d_instr, 32'h0);
        chk("mis_next", bus.im_addr, 32'h3006);
        redirect(32'h2ffc);
        edges(1);
        chk("low_err", {31'h0, bus.d_fetch_err}, 32'h1);
        chk("low_next", bus.im_addr, 32'h3000);
        redirect(32'h7000);
        edges(1);
        chk("high_err", {31'h0, bus.d_fetch_err}, 32'h1);
        chk("high_next", bus.im_addr, 32'h7004);

        // Window edge and 32-bit wrap
        redirect(32'h6ffc);
        edges(1);
        chk("lim_err", {31'h0, bus.d_fetch_err}, 32'h0);
        edges(1);
        chk("over_pc", bus.d_pc, 32'h7000);
        chk("over_err", {31'h0, bus.d_fetch_err}, 32'h1);
        redirect(32'hffff_fffc);
        edges(1);
        chk("wrap_pc", bus.im_addr, 32'h0);

        // Mixed pattern for the model
        for (int i = 0; i < 12; i++) begin
            bus.stall = (i % 3 == 1);
            bus.flush = (i % 5 == 2);
            bus.redirect_valid = (i % 4 == 0);
            bus.redirect_pc    = 32'h3100 + 32'(i * 8);
            edges(1);
        end
        bus.stall = 1'b0;
        bus.flush = 1'b0;

        // Mid-cycle reset with a pending redirect
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h3200;
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_pc", bus.im_addr, 32'h3000);
        chk("mid_rst_valid", {31'h0, bus.d_valid}, 32'h0);
        chk("mid_rst_dpc", bus.d_pc, 32'h0);
        edges(1);
        bus.redirect_valid = 1'b0;
        reset = 1'b0;
        edges(1);
        chk("post_rst_pc", bus.d_pc, 32'h3000);
        edges(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
